// File: rtl/key_expand_seq.sv
// key_expand_seq: sequential AES-128/192/256 key expander, one schedule word per clock,
// with a shared 4-S-box SubWord path and a registered round-key read port.
module key_expand_seq #(
   parameter bit SUPPORT_256    = 1'b1,
   parameter bit RD_ZERO_ON_ERR = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         key_ready,
   output logic         done,
   output logic         err,
   output logic [3:0]   num_rounds,
   input  logic         rd_en,
   input  logic [3:0]   rd_round,
   output logic [127:0] rd_key,
   output logic         rd_valid
);
   localparam int NW = SUPPORT_256 ? 60 : 52;
   localparam logic [1:0] IDLE = 2'd0, GEN = 2'd1, READY = 2'd2;
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   logic [1:0]   state_q, state_d, len_q, len_d;
   logic [5:0]   i_q, i_d;
   logic [2:0]   m_q, m_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [3:0]   nr_q, nr_d;
   logic         done_q, done_d, err_q, err_d, rd_valid_q, rd_valid_d;
   logic [127:0] rd_key_q, rd_key_d;
   logic [31:0]  w_q [NW];
   logic [31:0]  w_d [NW];
   logic [5:0]   nk, nk_new, ntot, base;
   logic [2:0]   m_last;
   logic         legal, accept;
   logic [31:0]  prev, sw, temp;

   always_comb begin
      nk     = (len_q == 2'b00) ? 6'd4 : (len_q == 2'b01) ? 6'd6 : 6'd8;
      nk_new = (key_len == 2'b00) ? 6'd4 : (key_len == 2'b01) ? 6'd6 : 6'd8;
      ntot   = {nk[3:0], 2'b00} + 6'd28;
      m_last = 3'(nk - 6'd1);
      legal  = (key_len != 2'b11) && (SUPPORT_256 || key_len != 2'b10);
      accept = start && state_q != GEN && legal;
      // m_q is i mod Nk; the single SubWord instance serves both the RotWord and the Nk=8 mid-block step
      prev   = w_q[i_q - 6'd1];
      sw     = sub_word(m_q == 3'd0 ? {prev[23:0], prev[31:24]} : prev);
      temp   = (m_q == 3'd0) ? sw ^ {rcon_q, 24'h0} : (nk == 6'd8 && m_q == 3'd4) ? sw : prev;
      state_d = state_q;
      len_d   = len_q;
      i_d     = i_q;
      m_d     = m_q;
      rcon_d  = rcon_q;
      nr_d    = nr_q;
      done_d  = 1'b0;
      err_d   = start && state_q != GEN && !legal;
      w_d     = w_q;
      if (accept) begin
         state_d = GEN;
         len_d   = key_len;
         i_d     = nk_new;
         m_d     = 3'd0;
         rcon_d  = 8'h01;
         nr_d    = nk_new[3:0] + 4'd6;
         for (int k = 0; k < 8; k++)
            if (k < int'(nk_new)) w_d[k] = key_in[255 - 32*k -: 32];
      end else if (state_q == GEN) begin
         w_d[i_q] = w_q[i_q - nk] ^ temp;
         i_d      = i_q + 6'd1;
         m_d      = (m_q == m_last) ? 3'd0 : m_q + 3'd1;
         rcon_d   = (m_q == 3'd0) ? {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00) : rcon_q;
         if (i_q == ntot - 6'd1) begin
            state_d = READY;
            done_d  = 1'b1;
         end
      end
      base       = {rd_round, 2'b00};
      rd_valid_d = rd_en && key_ready && rd_round <= nr_q;
      rd_key_d   = rd_valid_d ? {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]}
                 : RD_ZERO_ON_ERR ? '0 : rd_key_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         i_q        <= '0;
         m_q        <= '0;
         rcon_q     <= '0;
         nr_q       <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_key_q   <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         i_q        <= i_d;
         m_q        <= m_d;
         rcon_q     <= rcon_d;
         nr_q       <= nr_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rd_valid_q <= rd_valid_d;
         rd_key_q   <= rd_key_d;
      end
   end

   // Buffer contents are masked by key_ready, so it needs no reset
   always_ff @(posedge clk) w_q <= w_d;

   assign busy       = state_q == GEN;
   assign key_ready  = state_q == READY;
   assign done       = done_q;
   assign err        = err_q;
   assign num_rounds = nr_q;
   assign rd_key     = rd_key_q;
   assign rd_valid   = rd_valid_q;
endmodule

// File: tb/tb_key_expand_seq.sv
// tb_key_expand_seq: FIPS-197 vectors, corner sequences and random keys checked against
// a reference key schedule built from GF(2^8) arithmetic.
module tb_key_expand_seq;
   logic         clk, rst_n, start, rd_en;
   logic [1:0]   key_len;
   logic [255:0] key_in;
   logic [3:0]   rd_round, num_rounds;
   logic         busy, key_ready, done, err, rd_valid;
   logic [127:0] rd_key;
   int           passed, total;
   logic [7:0]   sb [256];
   logic [31:0]  mw [60];

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   typedef struct {
      logic [1:0]   len;
      logic [255:0] key;
      logic [3:0]   rnd;
      logic [127:0] exp;
   } vec_t;
   vec_t vecs [4];

   key_expand_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
      .busy(busy), .key_ready(key_ready), .done(done), .err(err), .num_rounds(num_rounds),
      .rd_en(rd_en), .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction

   task automatic expand(input logic [1:0] len, input logic [255:0] key);
      int nk, ntot;
      logic [31:0] t;
      logic [7:0] rc;
      nk   = 4 + 2*int'(len);
      ntot = 4*(nk + 7);
      rc   = 8'h01;
      for (int i = 0; i < ntot; i++) begin
         if (i < nk) mw[i] = key[255 - 32*i -: 32];
         else begin
            t = mw[i-1];
            if (i % nk == 0) begin
               t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) t = subw(t);
            mw[i] = mw[i-nk] ^ t;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h required %0h", nm, act, exp);
      else passed++;
   endtask

   task automatic rd(input logic [3:0] r, output logic v, output logic [127:0] k);
      @(negedge clk);
      rd_en    = 1'b1;
      rd_round = r;
      @(negedge clk);
      v     = rd_valid;
      k     = rd_key;
      rd_en = 1'b0;
   endtask

   task automatic run(input logic [1:0] len, input logic [255:0] key, input int inj, input bit rdg);
      int lat, bad, errs, nk;
      nk = 4 + 2*int'(len);
      @(negedge clk);
      start   = 1'b1;
      key_len = len;
      key_in  = key;
      @(negedge clk);
      start    = 1'b0;
      rd_en    = rdg;
      rd_round = 4'd0;
      chk("accept_busy_keyready", 160'({busy, key_ready}), 160'(2'b10));
      lat  = 0;
      bad  = 0;
      errs = 0;
      while (lat < 200 && !done) begin
         @(negedge clk);
         lat++;
         if (rd_valid) bad++;
         if (err) errs++;
         start = (lat == inj);
         if (lat == inj) begin
            key_in  = ~key;
            key_len = 2'b01;
         end
      end
      start = 1'b0;
      rd_en = 1'b0;
      chk("latency", 160'(lat), 160'(4*(nk + 7) - nk));
      chk("num_rounds", 160'(num_rounds), 160'(nk + 6));
      if (rdg) chk("gen_read_valid_count", 160'(bad), 160'(0));
      if (inj >= 0) chk("gen_start_err_count", 160'(errs), 160'(0));
      @(negedge clk);
      chk("done_pulse_ready", 160'({done, key_ready, busy}), 160'(3'b010));
   endtask

   initial begin
      logic v;
      logic [127:0] k;
      logic [1:0] len;
      logic [255:0] key;
      int nr;
      logic [7:0] inv;
      passed   = 0;
      total    = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      rd_en    = 1'b0;
      key_len  = 2'b00;
      key_in   = '0;
      rd_round = 4'd0;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      end
      vecs[0] = '{2'b00, K128, 4'd10, A1_R10};
      vecs[1] = '{2'b00, K128, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
      vecs[2] = '{2'b01, K192, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
      vecs[3] = '{2'b10, K256, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
      repeat (3) @(negedge clk);
      chk("reset_outputs", 160'({busy, key_ready, done, err, rd_valid, num_rounds, rd_key}), 160'(0));
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run(vecs[i].len, vecs[i].key, -1, 1'b0);
         rd(vecs[i].rnd, v, k);
         chk("vec_valid", 160'(v), 160'(1));
         chk("vec_round_key", 160'(k), 160'(vecs[i].exp));
      end
      @(negedge clk);
      start   = 1'b1;
      key_len = 2'b11;
      key_in  = K128;
      @(negedge clk);
      start = 1'b0;
      chk("reject_err", 160'({err, key_ready, busy}), 160'(3'b110));
      @(negedge clk);
      chk("reject_err_pulse", 160'({err, key_ready}), 160'(2'b01));
      rd(4'd14, v, k);
      chk("reject_buffer_kept", 160'({v, k}), 160'({1'b1, vecs[3].exp}));
      run(2'b00, K128, -1, 1'b0);
      rd(4'd10, v, k);
      chk("range_in", 160'({v, k}), 160'({1'b1, A1_R10}));
      rd(4'd11, v, k);
      chk("range_out_zero", 160'({v, k}), 160'(0));
      run(2'b00, K128, 10, 1'b1);
      rd(4'd10, v, k);
      chk("collision_result", 160'({v, k}), 160'({1'b1, A1_R10}));
      for (int n = 0; n < 6; n++) begin
         len = 2'($urandom_range(0, 2));
         key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         expand(len, key);
         nr = 10 + 2*int'(len);
         run(len, key, -1, 1'b0);
         for (int r = 0; r <= nr; r++) begin
            rd(4'(r), v, k);
            chk("rand_round", 160'({v, k}), 160'({1'b1, mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]}));
         end
         rd(4'(nr + 1), v, k);
         chk("rand_out_of_range", 160'({v, k}), 160'(0));
      end
      @(negedge clk);
      start   = 1'b1;
      key_len = 2'b00;
      key_in  = K128;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      chk("pre_reset_busy", 160'({busy, num_rounds}), 160'({1'b1, 4'd10}));
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", 160'({busy, key_ready, done, err, rd_valid, num_rounds, rd_key}), 160'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset_idle", 160'({busy, key_ready, done}), 160'(0));
      rd(4'd0, v, k);
      chk("post_reset_read", 160'(v), 160'(0));
      run(2'b00, K128, -1, 1'b0);
      rd(4'd10, v, k);
      chk("post_reset_a1", 160'({v, k}), 160'({1'b1, A1_R10}));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
